// File: rtl/lcd_hexfmt_if.sv
// Formatter-side bundle for lcd_hexfmt: update request, labels, values and the frame/status outputs.
interface lcd_hexfmt_if #(
   parameter int LBL_CHARS  = 8,
   parameter int HEX_DIGITS = 8
);
   logic                                         upd;
   logic [8*LBL_CHARS-1:0]                       label0;
   logic [8*LBL_CHARS-1:0]                       label1;
   logic [4*HEX_DIGITS-1:0]                      val0;
   logic [4*HEX_DIGITS-1:0]                      val1;
   logic [16*(LBL_CHARS+HEX_DIGITS)-1:0]         strdata;
   logic                                         busy;
   logic                                         done;

   modport master (
      output upd, label0, label1, val0, val1,
      input  strdata, busy, done
   );

   modport slave (
      input  upd, label0, label1, val0, val1,
      output strdata, busy, done
   );
endinterface

// File: rtl/lcd_hexfmt.sv
// Builds the 32-character LCD frame (label + hex value per line), one hex digit per clock, committed atomically.
// Optional leading-zero suppression per line when LCD_ZSUPPRESS_EN is defined.
module lcd_hexfmt #(
   parameter int         LBL_CHARS  = 8,
   parameter int         HEX_DIGITS = 8,
   parameter logic [7:0] BLANK      = 8'h20
) (
   input logic          CCLK,
   input logic          reset,
   lcd_hexfmt_if.slave  bus
);

   localparam int LINE = LBL_CHARS + HEX_DIGITS;
   localparam int NDIG = 2 * HEX_DIGITS;
   localparam int IDXW = $clog2(NDIG);
   localparam int POSW = $clog2(2 * LINE);

   typedef enum logic [1:0] {
      IDLE,
      CONV,
      COMMIT
   } state_t;

   state_t                  state;
   state_t                  state_next;
   logic                    start;
   logic [IDXW-1:0]         idx;
   logic                    pending;
   logic                    done_q;
   logic                    nz;
   logic [4*NDIG-1:0]       vals;
   logic [0:2*LINE-1][7:0]  shadow;
   logic [0:2*LINE-1][7:0]  frame;

   logic [3:0]              nibble;
   logic [IDXW-1:0]         dig;
   logic [POSW-1:0]         pos;
   logic [7:0]              digit_char;
   logic                    seen_now;

   always_ff @(posedge CCLK or negedge reset) begin
      if (!reset) begin
         state <= IDLE;
      end else begin
         state <= state_next;
      end
   end

   always_comb begin
      state_next = state;
      start      = 1'b0;
      case (state)
         IDLE: begin
            if (bus.upd || pending) begin
               start      = 1'b1;
               state_next = CONV;
            end
         end
         CONV: begin
            if (idx == IDXW'(NDIG - 1)) begin
               state_next = COMMIT;
            end
         end
         COMMIT:  state_next = IDLE;
         default: state_next = IDLE;
      endcase
   end

   // The snapshot is shifted left each digit, so the current nibble is always at the top.
   always_comb begin
      nibble     = vals[4*NDIG-1 -: 4];
      dig        = idx % IDXW'(HEX_DIGITS);
      pos        = (idx >= IDXW'(HEX_DIGITS)) ? (POSW'(LINE + LBL_CHARS) + POSW'(dig))
                                              : (POSW'(LBL_CHARS) + POSW'(dig));
      seen_now   = (nibble != 4'h0) || ((dig != '0) && nz);
      digit_char = (nibble < 4'd10) ? (8'h30 + {4'h0, nibble}) : (8'h37 + {4'h0, nibble});
`ifdef LCD_ZSUPPRESS_EN
      if (!seen_now && (dig != IDXW'(HEX_DIGITS - 1))) begin
         digit_char = BLANK;
      end
`else
`endif
   end

   always_ff @(posedge CCLK or negedge reset) begin
      if (!reset) begin
         idx     <= '0;
         pending <= 1'b0;
         done_q  <= 1'b0;
         nz      <= 1'b0;
         vals    <= '0;
         shadow  <= {(2*LINE){BLANK}};
         frame   <= {(2*LINE){BLANK}};
      end else begin
         done_q <= 1'b0;
         case (state)
            IDLE: begin
               if (start) begin
                  shadow[0 +: LBL_CHARS]    <= bus.label0;
                  shadow[LINE +: LBL_CHARS] <= bus.label1;
                  vals    <= {bus.val0, bus.val1};
                  idx     <= '0;
                  nz      <= 1'b0;
                  pending <= 1'b0;
               end
            end
            CONV: begin
               shadow[pos] <= digit_char;
               nz          <= seen_now;
               vals        <= vals << 4;
               idx         <= idx + 1'b1;
               if (bus.upd) begin
                  pending <= 1'b1;
               end
            end
            COMMIT: begin
               frame  <= shadow;
               done_q <= 1'b1;
               if (bus.upd) begin
                  pending <= 1'b1;
               end
            end
            default: ;
         endcase
      end
   end

   assign bus.strdata = frame;
   assign bus.busy    = (state != IDLE);
   assign bus.done    = done_q;

endmodule

// File: doc/lcd_hexfmt.md
Name: lcd_hexfmt

Overview:
- Formatter stage directly upstream of the LCD display driver.
- Builds the 256-bit, 32-character ASCII frame consumed on the driver's strdata input.
- Each line carries an 8-character label and an 8-digit hex value. Hex conversion runs one nibble per cycle into a shadow buffer.
- The frame output changes atomically, so the LCD never shows a half-updated frame.

Parameters:
- LBL_CHARS, 8: label characters per line. LBL_CHARS + HEX_DIGITS must equal 16.
- HEX_DIGITS, 8: hex digits per line; each value input is 4*HEX_DIGITS bits wide.
- BLANK, 8'h20: character used for reset fill and suppressed zeros.

Ports:
- CCLK, input, 1: system clock; all state updates on the rising edge.
- reset, input, 1: asynchronous, active-low reset.
- upd, input, 1: update request. Sampled every edge; level or pulse.
- label0, input, 64: line-1 label. label0[63:56] is the leftmost character.
- label1, input, 64: line-2 label, same ordering.
- val0, input, 32: line-1 value.
- val1, input, 32: line-2 value.
- strdata, output, 256: frame to the LCD driver. Character k (0 = top-left, 16 = bottom-left) is strdata[255-8k -: 8].
- busy, output, 1: a conversion or commit is in progress.
- done, output, 1: one-cycle pulse on the edge strdata is updated.

Behaviour:
- Reset (reset=0, asynchronous):
  - strdata = 32 x BLANK.
  - busy=0, done=0, pending flag=0.
  - State goes to IDLE; digit index=0; shadow buffer = 32 x BLANK.
  - Reset asserted mid-conversion aborts it; strdata returns to all-BLANK immediately.
- State machine: IDLE -> CONV -> COMMIT -> IDLE.
- IDLE:
  - On an edge with upd=1 or pending=1: snapshot label0/label1/val0/val1.
  - Write the labels into shadow chars 0-7 and 16-23; clear pending; set busy=1; digit index=0; go to CONV.
- CONV, 16 edges, index 0..15, one digit per edge:
  - idx 0-7: nibble val0[31-4i -: 4] -> char 8+i.
  - idx 8-15: nibble val1[31-4(i-8) -: 4] -> char 16+i.
  - Nibble 0-9 -> 8'h30+n; nibble A-F -> 8'h41+(n-10), uppercase.
  - After idx 15, go to COMMIT.
- COMMIT, one edge: strdata <= shadow; done=1 for that cycle; busy=0; go to IDLE.
- Latency:
  - upd sampled at edge t in IDLE -> strdata and done change at edge t+17.
  - busy is high from t through t+16 inclusive.
- upd while busy (CONV or COMMIT): set pending; do not restart.
  - At most one request is queued; further upd pulses merge into it.
  - The queued request snapshots inputs at the IDLE edge following COMMIT, not at the time upd was asserted.
  - That IDLE edge comes directly after COMMIT, so busy is low for exactly one cycle between back-to-back frames.
- Input changes during CONV do not affect the frame in progress; only the snapshot is used.
- strdata holds its value between commits. The labels are never altered and contain no conversion.

Optional Feature:
- Macro: LCD_ZSUPPRESS_EN.
- Defined: leading-zero suppression per line.
  - Scanning MSB first, a digit is replaced by BLANK if it and all earlier digits of the same line are zero.
  - The last digit of each line (char 15, char 31) is never blanked.
  - The "nonzero seen" flag clears at idx 0 and idx 8.
  - Latency unchanged.
- Undefined: all 8 digits always shown, including leading zeros.

Test Plan:
- Reset released, no upd -> strdata = 256 bits of 8'h20 repeated; busy=0; done=0.
- label0="PC=     ", val0=32'h0040_1A2C, label1="INSTR=  ", val1=32'hDEADBEEF, single upd pulse at edge t:
  - done=1 at t+17; busy high t..t+16.
  - Without the macro: line 1 = "PC=     00401A2C", line 2 = "INSTR=  DEADBEEF".
  - With LCD_ZSUPPRESS_EN: line 1 = "PC=       401A2C".
- With LCD_ZSUPPRESS_EN, val0=0, val1=32'h0000_0001:
  - chars 8-14 and 24-30 = 8'h20; char 15 = "0"; char 31 = "1".
- upd pulses at t, t+5 and t+9; val0 changed to 32'h1111_1111 at t+12:
  - First frame shows the old val0 at t+17.
  - Exactly one more frame starts at t+18 and commits at t+35 with 11111111.
  - Exactly two done pulses total.
- val0 changed at t+3 during CONV -> frame committed at t+17 shows the value snapshotted at t.
- reset asserted at t+8 mid-conversion, upd held low afterward -> strdata = all 8'h20 asynchronously; busy=0; no done pulse; pending cleared.
